mux2_arbiter: RTL and testbench
===============================

MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have a single clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- req0  in  1  requester 0 has data.
- data0  in  2  requester 0 payload, stable while req0=1.
- req1  in  1  requester 1 has data.
- data1  in  2  requester 1 payload, stable while req1=1.
- gnt0  out  1  requester 0 payload accepted this cycle.
- gnt1  out  1  requester 1 payload accepted this cycle.
- out_valid  out  1  out_data holds an unconsumed word.
- out_data  out  2  registered payload of the shared channel.
- out_src  out  1  source of out_data (0 = requester 0, 1 = requester 1).
- out_ready  in  1  consumer accepts out_data when out_valid=1.
- xfer_cnt  out  8  count of completed output transfers, wraps 255->0.
REQ-003 SHALL use parameter W, default 2, the payload width (fixed at 2 in this release).

Function
REQ-004 SHALL implement FSM states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-005 SHALL hold a 1-bit round-robin pointer prio.
- prio names the favoured requester.
- prio resets to 0.
REQ-006 SHALL define "slot free" as (state=IDLE) or (state=HOLD and out_ready=1).
REQ-007 SHALL drive gnt0/gnt1 combinationally:
- They are asserted only when the slot is free.
- When exactly one req is high, that requester wins.
- When both reqs are high, requester prio wins.
- At most one grant is high in any cycle.
REQ-008 SHALL act on each rising edge where a grant is high to requester i:
- out_data <= data_i, routed through the payload mux with select = i.
- out_src <= i.
- prio <= ~i.
- state <= HOLD.
REQ-009 SHALL have a latency of one cycle from grant to out_valid=1.
REQ-010 SHALL move HOLD to IDLE when out_ready=1 and no grant is issued.
- out_data and out_src keep their last values in IDLE.
REQ-011 SHALL stay in HOLD, keeping out_data, out_src and prio unchanged, when out_ready=0 (backpressure); no grant is issued.
REQ-012 SHALL sustain one transfer per cycle when out_ready=1 and requests are continuous.
- Simultaneous consume and capture keeps state HOLD.
REQ-013 SHALL increment xfer_cnt by 1 on each edge where out_valid=1 and out_ready=1, wrapping modulo 256.
REQ-014 SHALL ignore out_ready while in IDLE (no count, no state change).
REQ-015 SHALL not change prio when no grant is issued.

Reset
REQ-016 SHALL, on any rising edge with rst_n=0, set: state=IDLE, out_valid=0, out_data=00, out_src=0, prio=0, xfer_cnt=0.
REQ-017 SHALL force gnt0=gnt1=0 while rst_n=0.
REQ-018 SHALL, on reset asserted mid-transfer (HOLD), discard the held word with no count increment; the first grant after release favours requester 0.

Structure
REQ-019 SHALL place state encodings (IDLE=0, HOLD=1) and W in the shared design package used across the codebase's blocks.
REQ-020 SHALL instantiate the existing 2-bit 2:1 gate-level mux, mux2_1, as its one sub-module for payload selection.
- Inputs: in1=data1, in2=data0.
- Select: s=winning index.

Verification
REQ-021 SHALL cover a single request: req0=1, data0=10 in IDLE -> gnt0=1 that cycle; next cycle out_valid=1, out_data=10, out_src=0, prio=1.
REQ-022 SHALL cover contention: req0=req1=1 continuously, data0=01, data1=11, out_ready=1, from reset -> grants alternate 0,1,0,1; out_data sequence 01,11,01,11; one transfer per cycle.
REQ-023 SHALL cover backpressure: HOLD with out_data=11, out_ready=0 for 3 cycles while req0=1 -> gnt0=0 throughout; out_data stays 11; xfer_cnt unchanged; on out_ready=1, gnt0=1 in that same cycle.
REQ-024 SHALL cover counter wrap: 256 accepted transfers from reset -> xfer_cnt reads 0; 257th transfer -> 1.
REQ-025 SHALL cover mid-transfer reset: rst_n=0 for one edge while HOLD with out_valid=1 -> next cycle out_valid=0, xfer_cnt=0; with both reqs high after release, gnt0 wins first.
REQ-026 SHALL cover drain to idle: HOLD, out_ready=1, no reqs -> next cycle IDLE, out_valid=0, out_data retained.

Source files
------------

// File: rtl/mux2_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux2_arbiter_pkg
// Shared definitions for the two-requester arbiter:
//   W       - payload width (fixed at 2 in this release)
//   state_t - arbiter FSM encoding (IDLE = 0, HOLD = 1)
// -----------------------------------------------------------------------------
package mux2_arbiter_pkg;

    localparam int W = 2;

    // IDLE: output register empty. HOLD: output register holds an unconsumed word.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/mux2_1.sv
// -----------------------------------------------------------------------------
// mux2_1
// 2-bit 2:1 multiplexer built from gate primitives.
// Ports:
//   in1 [1:0] in  - selected when s = 1
//   in2 [1:0] in  - selected when s = 0
//   s         in  - select
//   out [1:0] out - selected word
// -----------------------------------------------------------------------------
module mux2_1 (
    input  logic [1:0] in1,
    input  logic [1:0] in2,
    input  logic       s,
    output logic [1:0] out
);

    logic       s_n;
    logic [1:0] and_hi;
    logic [1:0] and_lo;

    not u_inv (s_n, s);

    genvar i;
    generate
        for (i = 0; i < 2; i++) begin : g_bit
            and u_and_hi (and_hi[i], in1[i], s);
            and u_and_lo (and_lo[i], in2[i], s_n);
            or  u_or     (out[i], and_hi[i], and_lo[i]);
        end
    endgenerate

endmodule

// File: rtl/mux2_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_arbiter
// Round-robin arbiter that merges two requesters onto one registered output
// channel with valid/ready flow control.
// Ports:
//   clk, rst_n          - rising-edge clock, synchronous active-low reset
//   req0, data0         - requester 0 request / payload
//   req1, data1         - requester 1 request / payload
//   gnt0, gnt1          - combinational grants (payload accepted this cycle)
//   out_valid           - out_data holds an unconsumed word (FSM in HOLD)
//   out_data, out_src   - registered payload and its source requester
//   out_ready           - consumer accepts out_data when out_valid = 1
//   xfer_cnt            - completed output transfers, wraps 255 -> 0
//
// Handshake: a word moves on the output channel on every rising edge where
// out_valid = 1 and out_ready = 1. A requester's payload is accepted on every
// rising edge where its grant is high; grants are only issued when the output
// slot is free (empty, or being consumed on the same edge).
// The FSM state is visible directly as out_valid.
// -----------------------------------------------------------------------------
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int W = mux2_arbiter_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [W-1:0] data0,
    input  logic         req1,
    input  logic [W-1:0] data1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_src,
    input  logic         out_ready,
    output logic [7:0]   xfer_cnt
);

    state_t       state;
    state_t       state_next;
    logic         prio;
    logic         slot_free;
    logic         win_idx;
    logic         grant_any;
    logic [W-1:0] mux_out;

    // Payload selection: s = 1 picks requester 1.
    mux2_1 u_mux (
        .in1 (data1),
        .in2 (data0),
        .s   (win_idx),
        .out (mux_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a capture always lands in HOLD (also covers the
    // simultaneous consume + capture case); a consume without capture drains.
    always_comb begin
        state_next = state;
        if (grant_any) begin
            state_next = HOLD;
        end else if (state == HOLD && out_ready) begin
            state_next = IDLE;
        end
    end

    // Output / arbitration logic
    always_comb begin
        out_valid = (state == HOLD);
        slot_free = (state == IDLE) || out_ready;
        // With both requesting the favoured one wins; otherwise whoever asks.
        win_idx   = (req0 && req1) ? prio : req1;
        gnt0      = rst_n && slot_free && (req0 || req1) && !win_idx;
        gnt1      = rst_n && slot_free && (req0 || req1) &&  win_idx;
        grant_any = gnt0 || gnt1;
    end

    // Datapath: output register, source tag, round-robin pointer, counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= 1'b0;
            prio     <= 1'b0;
            xfer_cnt <= 8'd0;
        end else begin
            if (grant_any) begin
                out_data <= mux_out;
                out_src  <= win_idx;
                prio     <= ~win_idx;
            end
            if (out_valid && out_ready) begin
                xfer_cnt <= xfer_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_arbiter
// Self-checking bench for mux2_arbiter: a directed vector table, hand-written
// multi-cycle sequences (contention, mid-transfer reset, counter wrap) and a
// randomized run checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, out_ready;
    logic [1:0] data0, data1;
    logic       gnt0, gnt1, out_valid, out_src;
    logic [1:0] out_data;
    logic [7:0] xfer_cnt;

    mux2_arbiter #(.W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_vec  = 0;
    int n_fail = 0;

    // ---------------- reference model state ----------------
    // Holds what the channel should show; "last winner" drives round robin.
    bit       m_valid;
    bit [1:0] m_data;
    bit       m_src;
    int       m_cnt;
    bit       m_last;   // 1 after reset so requester 0 is favoured first

    typedef struct {
        bit       rstn;
        bit       r0;
        bit [1:0] d0;
        bit       r1;
        bit [1:0] d1;
        bit       rdy;
        bit       g0;
        bit       g1;
        bit       valid;
        bit [1:0] data;
        bit       src;
        int       cnt;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t tv(bit rstn, bit r0, bit [1:0] d0, bit r1, bit [1:0] d1,
                                bit rdy, bit g0, bit g1, bit valid, bit [1:0] data,
                                bit src, int cnt);
        vec_t v;
        v.rstn = rstn; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.rdy = rdy;
        v.g0 = g0; v.g1 = g1; v.valid = valid; v.data = data; v.src = src; v.cnt = cnt;
        return v;
    endfunction

    function automatic vec_t iv(bit rstn, bit r0, bit [1:0] d0, bit r1, bit [1:0] d1, bit rdy);
        return tv(rstn, r0, d0, r1, d1, rdy, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns later, then
    // advance the model across the coming rising edge.
    task automatic step(input bit chk_en, input bit use_tbl, input vec_t v);
        bit any, free, win, eg0, eg1;
        @(negedge clk);
        rst_n     = v.rstn;
        req0      = v.r0;
        data0     = v.d0;
        req1      = v.r1;
        data1     = v.d1;
        out_ready = v.rdy;
        #1;
        any  = v.r0 | v.r1;
        free = !m_valid || v.rdy;
        win  = (v.r0 && v.r1) ? ~m_last : v.r1;
        eg0  = v.rstn && free && any && !win;
        eg1  = v.rstn && free && any &&  win;
        if (chk_en) begin
            if (use_tbl) begin
                chk("tbl_gnt0",      gnt0,      v.g0);
                chk("tbl_gnt1",      gnt1,      v.g1);
                chk("tbl_out_valid", out_valid, v.valid);
                chk("tbl_out_data",  out_data,  v.data);
                chk("tbl_out_src",   out_src,   v.src);
                chk("tbl_xfer_cnt",  xfer_cnt,  v.cnt);
            end else begin
                chk("mdl_gnt0",      gnt0,      eg0);
                chk("mdl_gnt1",      gnt1,      eg1);
                chk("mdl_out_valid", out_valid, m_valid);
                if (m_valid || m_cnt > 0 || m_src || m_data != 0) begin
                    chk("mdl_out_data", out_data, m_data);
                    chk("mdl_out_src",  out_src,  m_src);
                end
                chk("mdl_xfer_cnt",  xfer_cnt,  m_cnt);
            end
        end
        if (!v.rstn) begin
            m_valid = 0; m_data = 0; m_src = 0; m_cnt = 0; m_last = 1;
        end else begin
            if (m_valid && v.rdy) m_cnt = (m_cnt + 1) % 256;
            if (eg0 || eg1) begin
                m_data  = win ? v.d1 : v.d0;
                m_src   = win;
                m_last  = win;
                m_valid = 1;
            end else if (m_valid && v.rdy) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, iv(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0));
        step(1'b1, 1'b0, iv(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0));
    endtask

    initial begin
        bit       r0, r1, rdy, rstn;
        bit [1:0] d0, d1;

        m_valid = 0; m_data = 0; m_src = 0; m_cnt = 0; m_last = 1;

        // ---------------- directed table ----------------
        //          rstn r0 d0   r1 d1   rdy  g0 g1 vld data src cnt
        tbl[0]  = tv(1, 1, 2'b10, 0, 2'b00, 0,  1, 0, 0, 2'b00, 0, 0); // single request
        tbl[1]  = tv(1, 0, 2'b00, 0, 2'b00, 0,  0, 0, 1, 2'b10, 0, 0); // held, prio now 1
        tbl[2]  = tv(1, 1, 2'b01, 1, 2'b11, 1,  0, 1, 1, 2'b10, 0, 0); // both: 1 favoured
        tbl[3]  = tv(1, 1, 2'b01, 1, 2'b11, 1,  1, 0, 1, 2'b11, 1, 1);
        tbl[4]  = tv(1, 1, 2'b01, 1, 2'b11, 1,  0, 1, 1, 2'b01, 0, 2);
        tbl[5]  = tv(1, 1, 2'b01, 0, 2'b00, 0,  0, 0, 1, 2'b11, 1, 3); // backpressure x3
        tbl[6]  = tv(1, 1, 2'b01, 0, 2'b00, 0,  0, 0, 1, 2'b11, 1, 3);
        tbl[7]  = tv(1, 1, 2'b01, 0, 2'b00, 0,  0, 0, 1, 2'b11, 1, 3);
        tbl[8]  = tv(1, 1, 2'b01, 0, 2'b00, 1,  1, 0, 1, 2'b11, 1, 3); // release: same-cycle grant
        tbl[9]  = tv(1, 0, 2'b00, 0, 2'b00, 1,  0, 0, 1, 2'b01, 0, 4); // drain
        tbl[10] = tv(1, 0, 2'b00, 0, 2'b00, 1,  0, 0, 0, 2'b01, 0, 5); // idle, data kept
        tbl[11] = tv(1, 0, 2'b00, 0, 2'b00, 1,  0, 0, 0, 2'b01, 0, 5); // ready ignored in idle

        rst_n = 0; req0 = 0; req1 = 0; data0 = 0; data1 = 0; out_ready = 0;

        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, tbl[i]);

        // ---------------- contention from reset ----------------
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, iv(1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 1'b1));
            chk("contend_gnt1", gnt1, (k % 2));
            if (k > 0) chk("contend_data", out_data, ((k - 1) % 2) ? 2'b11 : 2'b01);
        end

        // ---------------- mid-transfer reset ----------------
        chk("midrst_pre_valid", out_valid, 1'b1);
        step(1'b1, 1'b0, iv(1'b0, 1'b1, 2'b01, 1'b1, 2'b11, 1'b0));
        chk("midrst_gnt_in_rst", {gnt1, gnt0}, 2'b00);
        step(1'b1, 1'b0, iv(1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 1'b0));
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_cnt",   xfer_cnt,  8'd0);
        chk("midrst_gnt0",  gnt0,      1'b1);

        // ---------------- counter wrap ----------------
        do_reset();
        for (int n = 0; n <= 258; n++) begin
            step(1'b1, 1'b0, iv(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 2'b00, 1'b1));
            if (n == 257) chk("wrap_256", xfer_cnt, 8'd0);
            if (n == 258) chk("wrap_257", xfer_cnt, 8'd1);
        end

        // ---------------- randomized run ----------------
        do_reset();
        r0 = 0; r1 = 0; d0 = 0; d1 = 0;
        for (int n = 0; n < 3000; n++) begin
            // Payload may only change when the requester is not waiting.
            if (!(r0 && !gnt0)) d0 = 2'($urandom_range(0, 3));
            if (!(r1 && !gnt1)) d1 = 2'($urandom_range(0, 3));
            r0   = ($urandom_range(0, 3) != 0);
            r1   = ($urandom_range(0, 2) != 0);
            rdy  = ($urandom_range(0, 9) < 7);
            rstn = ($urandom_range(0, 63) != 0);
            step(1'b1, 1'b0, iv(rstn, r0, d0, r1, d1, rdy));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
